// File: rtl/gray_code_pkg.sv
// gray_code_pkg: shared width default, count directions and the binary-to-Gray encode.
package gray_code_pkg;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam logic COUNT_UP = 1'b1;
    localparam logic COUNT_DOWN = 1'b0;

    function automatic logic [31:0] to_gray(input logic [31:0] binary);
        return binary ^ (binary >> 1);
    endfunction
endpackage

// File: rtl/binary_to_gray_converter_16_bit.sv
// binary_to_gray_converter_16_bit: combinational binary to reflected Gray encode.
module binary_to_gray_converter_16_bit
    import gray_code_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] binary,
    output logic [DATA_WIDTH-1:0] gray
);
    assign gray = DATA_WIDTH'(to_gray(32'(binary)));
endmodule

// File: rtl/gray_code_counter_16_bit.sv
// gray_code_counter_16_bit: loadable up/down counter with registered binary and Gray outputs.
// Gray is encoded from the next binary value so both outputs leave the same flops edge.
module gray_code_counter_16_bit
    import gray_code_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Up_Down_In,
    input  logic                  Load_In,
    input  logic [DATA_WIDTH-1:0] Binary_Load_In,
    output logic [DATA_WIDTH-1:0] Binary_Count_Out,
    output logic [DATA_WIDTH-1:0] Gray_Count_Out,
    output logic                  Wrap_Out
);
    logic [DATA_WIDTH-1:0] next_binary;
    logic [DATA_WIDTH-1:0] next_gray;
    logic                  next_wrap;
    logic                  up;

    always_comb begin
        up = Up_Down_In == COUNT_UP;
        next_binary = Load_In ? Binary_Load_In :
                      Enable_In ? (up ? Binary_Count_Out + DATA_WIDTH'(1)
                                      : Binary_Count_Out - DATA_WIDTH'(1)) :
                      Binary_Count_Out;
        // Loads never flag a wrap, only a real modulo step does.
        next_wrap = !Load_In && Enable_In && (up ? &Binary_Count_Out : ~|Binary_Count_Out);
    end

    binary_to_gray_converter_16_bit #(.DATA_WIDTH(DATA_WIDTH)) u_encode (
        .binary(next_binary),
        .gray  (next_gray)
    );

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            Binary_Count_Out <= '0;
            Gray_Count_Out   <= '0;
            Wrap_Out         <= 1'b0;
        end else begin
            Binary_Count_Out <= next_binary;
            Gray_Count_Out   <= next_gray;
            Wrap_Out         <= next_wrap;
        end
    end
endmodule
